// File: rtl/servive_gpio_logger.sv
// servive_gpio_logger
//
// Watches the servant GPIO bus and records every change of value. Each new value is
// queued in a small FIFO and sent out as an 8N1 UART frame (LSB first). This gives
// a serial trace of GPIO writes. The core is never stalled: when the FIFO is full,
// a change is dropped and the drop is counted.
//
// Parameters:
//   CLKS_PER_BIT  wb_clk cycles per UART bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
//
// Ports:
//   wb_clk        system clock, rising edge
//   wb_rst        synchronous active-high reset
//   i_q           8-bit GPIO bus, synchronous to wb_clk
//   o_tx          UART TX line, idle high, driven from a register
//   o_busy        FIFO non-empty or frame in progress
//   o_overflow    sticky drop flag, cleared only by reset
//   o_drop_count  dropped-change counter, saturates at 255

module servive_gpio_logger #(
  parameter int unsigned CLKS_PER_BIT = 139,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic [7:0] i_q,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_overflow,
  output logic [7:0] o_drop_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // Change detector
  logic [7:0] prev_q;
  logic       push;

  assign push = (i_q != prev_q);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      prev_q <= 8'h00;
    end else if (push) begin
      prev_q <= i_q;
    end
  end

  // FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, pop, accept, drop;
  logic [7:0]      head;

  assign full   = (count_q == CntW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (accept && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset; count_q gates every read.
  always_ff @(posedge wb_clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= i_q;
    end
  end

  // Overflow tracking
  logic       overflow_q;
  logic [7:0] drop_count_q;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= 8'h00;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_q <= drop_count_q + 8'h01;
      end
    end
  end

  // TX FSM
  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             baud_last;

  assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = head;
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        tx_d = shreg_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // tx_q follows the state one cycle late, keeping the pin glitch-free.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign o_tx         = tx_q;
  assign o_busy       = (state_q != StIdle) || (count_q != '0);
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_count_q;

endmodule

// File: doc/servive_gpio_logger.md
# servive_gpio_logger

Downstream consumer of the servant GPIO bus `q` on the servive board top. It samples the 8-bit bus every clock and detects value changes. Each new value goes into a small FIFO, and each queued byte is sent out as an 8N1 UART frame on a single pin. The block gives a serial trace of every GPIO write without a logic analyser; overflow is counted and flagged, never stalls the core.

## Interface
Parameters:
- `CLKS_PER_BIT`, 139, wb_clk cycles per UART bit (≥2); 139 ≈ 115200 baud at 16 MHz.
- `FIFO_DEPTH`, 4, FIFO entries; power of two, ≥2.

Ports:
- `wb_clk`  input  1  system clock; all logic on rising edge.
- `wb_rst`  input  1  synchronous, active-high reset.
- `i_q`  input  8  GPIO bus from servant, synchronous to `wb_clk`.
- `o_tx`  output  1  UART TX line, idle high.
- `o_busy`  output  1  high when the FIFO is non-empty or a frame is in progress.
- `o_overflow`  output  1  sticky; set when a change is dropped, cleared only by reset.
- `o_drop_count`  output  8  number of dropped changes, saturating at 255.

## Operation
- Change detector:
  - `prev` register, reset 0x00.
  - At an edge where `i_q != prev`: `prev <= i_q` and a push of `i_q` is requested.
  - Every change is detected, even one lasting a single cycle.
- FIFO:
  - `FIFO_DEPTH` x 8 bits, with read/write pointers that wrap modulo depth, plus a count of width clog2(depth)+1.
  - Push while full and not popping in the same cycle: data is dropped, `o_overflow` <= 1, and `o_drop_count` increments unless already 255.
  - Push while full and popping in the same cycle: the push is accepted and the count is unchanged.
  - Push and pop on a non-full FIFO: count is unchanged.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: `o_tx`=1. If the FIFO is non-empty: pop the head into `shreg`, clear the baud counter and bit index, go to START.
  - START: `o_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `o_tx`=`shreg[0]`. After each `CLKS_PER_BIT` cycles, shift right and increment the bit index. After bit 7, go to STOP. Bits are sent LSB first.
  - STOP: `o_tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `o_tx` is driven from a register, so it is glitch-free.
- `o_busy` = (state != IDLE) | (count != 0).
- Reset mid-frame: next cycle is IDLE, `o_tx`=1, FIFO is empty, and `prev`=0. The partial frame is abandoned.

## Timing
- Reset values:
  - `o_tx`=1, `o_busy`=0, `o_overflow`=0, `o_drop_count`=0.
  - FSM in IDLE; FIFO count, pointers and `prev` = 0.
- Let E be the edge at which the change is sampled; the FIFO write happens at E.
  - At E+1, IDLE sees non-empty and pops.
  - `o_tx` falls after E+2, so its start-bit low is first visible 2 cycles after the change is sampled.
- Frame: start bit low for `CLKS_PER_BIT` cycles, 8 data bits, stop bit high for `CLKS_PER_BIT` cycles.
- Back-to-back frames: one IDLE cycle between the end of STOP and the next start bit, so the frame period is 10·`CLKS_PER_BIT`+1 cycles.
- `o_busy` rises one cycle after E and falls one cycle after the last STOP cycle if the FIFO is empty.
- `o_overflow` and `o_drop_count` update at the same edge as the rejected push.
- Throughput limit: changes spaced closer than one frame period eventually overflow once `FIFO_DEPTH` entries plus the frame in flight are exhausted.

## Test plan
- Reset then idle, `i_q` held at 0x00 for 200 cycles: `o_tx`=1 and `o_busy`=0 throughout, with no frame sent.
- `CLKS_PER_BIT`=4, `i_q` steps 0x00→0xA5 and holds:
  - one frame, start bit low 2 cycles after the sampling edge;
  - bits sent 1,0,1,0,0,1,0,1 (LSB first), each 4 cycles, then stop high;
  - 40 cycles total; `o_busy` falls after it.
- `i_q` pulses 0x01 for a single cycle, then back to 0x00: two frames, 0x01 then 0x00, separated by exactly 1 idle cycle.
- Burst at `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4: 8 changes on consecutive cycles (0x01..0x08):
  - first byte is popped, 4 more are queued, remaining 3 are dropped;
  - `o_drop_count`=3, `o_overflow`=1;
  - frames 0x01..0x05 are sent in order.
- Full FIFO with push and pop in the same cycle: the push is accepted, `o_drop_count` is unchanged, and the pushed byte appears as the last frame.
- Assert `wb_rst` during the DATA bits of a 0xFF frame: `o_tx`=1 on the next cycle, `o_busy`=0, `o_overflow`=0, and there is no residual frame. After release, the existing `i_q`=0xFF is logged again.
